// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between CPU data port and one peripheral master
//
// Purpose: shares a single-port, 1-cycle synchronous-read data RAM between the
// processor data port (fixed priority) and one peripheral master. A starvation
// counter forces one peripheral slot, stalling the CPU for that cycle.
//
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   cpu_en/cpu_wren/cpu_addr/cpu_data CPU access request (load/store)
//   cpu_q, cpu_stall                  CPU load data, CPU hold request
//   per_req/per_wren/per_addr/per_data peripheral request, held until per_ack
//   per_ack, per_q, per_qvalid        peripheral grant, read data and strobe
//   ram_wen/ram_addr/ram_din/ram_dout RAM port (wEn/addr/dataIn/dataOut)
//   stat_per_grants, stat_stalls      16-bit wrapping counters (ARB_STATS_EN only)
//
// Optional feature macro: ARB_STATS_EN (adds the two statistics outputs).

module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 12,
    parameter int DW           = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          cpu_wren,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_stall,
    input  logic          per_req,
    input  logic          per_wren,
    input  logic [AW-1:0] per_addr,
    input  logic [DW-1:0] per_data,
    output logic          per_ack,
    output logic [DW-1:0] per_q,
    output logic          per_qvalid,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_per_grants,
    output logic [15:0]   stat_stalls
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PER  = 2'd2
    } owner_t;

    logic [7:0]    wait_cnt_q, wait_cnt_d;
    owner_t        owner_q, owner_d;
    logic [DW-1:0] cpu_hold_q, cpu_hold_d;
    logic [DW-1:0] per_hold_q, per_hold_d;

    logic force_grant;
    logic grant_cpu;
    logic grant_per;

    // Grant decision. Gated by reset so nothing reaches the RAM while in reset
    // and a pending peripheral request is not acked (it is dropped).
    always_comb begin
        force_grant = per_req && (wait_cnt_q == LIMIT);
        grant_per   = !reset && (force_grant || (!cpu_en && per_req));
        grant_cpu   = !reset && cpu_en && !force_grant;
        per_ack     = grant_per;
        cpu_stall   = !reset && force_grant && cpu_en;
    end

    // RAM mux: idle cycles park the address on the CPU port with writes off.
    always_comb begin
        if (grant_per) begin
            ram_addr = per_addr;
            ram_din  = per_data;
            ram_wen  = per_wren;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_data;
            ram_wen  = grant_cpu && cpu_wren;
        end
    end

    // Read data steering: the RAM output belongs to whoever read last cycle;
    // each master otherwise sees its own held copy, so a peripheral read never
    // disturbs cpu_q.
    always_comb begin
        cpu_q      = (owner_q == OWN_CPU) ? ram_dout : cpu_hold_q;
        per_q      = (owner_q == OWN_PER) ? ram_dout : per_hold_q;
        per_qvalid = (owner_q == OWN_PER);
        cpu_hold_d = cpu_q;
        per_hold_d = per_q;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (per_ack || !per_req) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        owner_d = OWN_NONE;
        if (grant_cpu && !cpu_wren) begin
            owner_d = OWN_CPU;
        end else if (grant_per && !per_wren) begin
            owner_d = OWN_PER;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
            owner_q    <= OWN_NONE;
            cpu_hold_q <= '0;
            per_hold_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            cpu_hold_q <= cpu_hold_d;
            per_hold_q <= per_hold_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_per_grants_q;
    logic [15:0] stat_stalls_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_per_grants_q <= 16'd0;
            stat_stalls_q     <= 16'd0;
        end else begin
            stat_per_grants_q <= stat_per_grants_q + {15'd0, per_ack};
            stat_stalls_q     <= stat_stalls_q + {15'd0, cpu_stall};
        end
    end

    assign stat_per_grants = stat_per_grants_q;
    assign stat_stalls     = stat_stalls_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_en, cpu_wren;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic [DW-1:0] cpu_q;
    logic          cpu_stall;
    logic          per_req, per_wren;
    logic [AW-1:0] per_addr;
    logic [DW-1:0] per_data;
    logic          per_ack;
    logic [DW-1:0] per_q;
    logic          per_qvalid;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_per_grants;
    logic [15:0]   stat_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_arbiter #(.STARVE_LIMIT(8), .AW(AW), .DW(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .cpu_wren   (cpu_wren),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_q      (cpu_q),
        .cpu_stall  (cpu_stall),
        .per_req    (per_req),
        .per_wren   (per_wren),
        .per_addr   (per_addr),
        .per_data   (per_data),
        .per_ack    (per_ack),
        .per_q      (per_q),
        .per_qvalid (per_qvalid),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
`ifdef ARB_STATS_EN
        ,
        .stat_per_grants (stat_per_grants),
        .stat_stalls     (stat_stalls)
`endif
    );

    always #10 clock = ~clock;

    // Single-port RAM with 1-cycle synchronous read (read-before-write).
    always @(posedge clock) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Advance to 1 time unit after the next rising edge; inputs change there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_en = 0; cpu_wren = 0; cpu_addr = '0; cpu_data = '0;
        per_req = 0; per_wren = 0; per_addr = '0; per_data = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (per_ack !== 1'b0)    begin failures++; $display("FAIL reset_per_ack got=%b exp=0", per_ack); end
        checks++; if (cpu_stall !== 1'b0)  begin failures++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
        checks++; if (ram_wen !== 1'b0)    begin failures++; $display("FAIL reset_ram_wen got=%b exp=0", ram_wen); end
        checks++; if (per_qvalid !== 1'b0) begin failures++; $display("FAIL reset_per_qvalid got=%b exp=0", per_qvalid); end
        checks++; if (cpu_q !== 32'h0)     begin failures++; $display("FAIL reset_cpu_q got=%h exp=0", cpu_q); end
        checks++; if (per_q !== 32'h0)     begin failures++; $display("FAIL reset_per_q got=%h exp=0", per_q); end
    endtask

    task automatic test_cpu_only();
        tick();
        cpu_en = 1; cpu_wren = 1; cpu_addr = 12'h010; cpu_data = 32'hDEADBEEF;
        #1;
        checks++; if (ram_wen !== 1'b1) begin failures++; $display("FAIL cpu_store_wen got=%b exp=1", ram_wen); end
        checks++; if (per_ack !== 1'b0) begin failures++; $display("FAIL cpu_store_ack got=%b exp=0", per_ack); end
        tick();
        cpu_wren = 0; cpu_data = '0;
        #1;
        checks++; if (ram_wen !== 1'b0)   begin failures++; $display("FAIL cpu_load_wen got=%b exp=0", ram_wen); end
        checks++; if (ram_addr !== 12'h010) begin failures++; $display("FAIL cpu_load_addr got=%h exp=010", ram_addr); end
        tick();
        cpu_en = 0;
        #1;
        checks++; if (cpu_q !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_load_q got=%h exp=deadbeef", cpu_q); end
        checks++; if (per_ack !== 1'b0)       begin failures++; $display("FAIL cpu_only_ack got=%b exp=0", per_ack); end
        tick();
        #1;
        checks++; if (cpu_q !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_q_hold got=%h exp=deadbeef", cpu_q); end
    endtask

    task automatic test_per_only();
        // Preload via a CPU store, then a peripheral read.
        tick();
        cpu_en = 1; cpu_wren = 1; cpu_addr = 12'h020; cpu_data = 32'h12345678;
        tick();
        idle_inputs();
        per_req = 1; per_addr = 12'h020;
        #1;
        checks++; if (per_ack !== 1'b1)     begin failures++; $display("FAIL per_read_ack got=%b exp=1", per_ack); end
        checks++; if (ram_addr !== 12'h020) begin failures++; $display("FAIL per_read_addr got=%h exp=020", ram_addr); end
        tick();
        per_req = 0;
        #1;
        checks++; if (per_qvalid !== 1'b1)    begin failures++; $display("FAIL per_qvalid got=%b exp=1", per_qvalid); end
        checks++; if (per_q !== 32'h12345678) begin failures++; $display("FAIL per_q got=%h exp=12345678", per_q); end
        tick();
        // Peripheral write: acked, reaches RAM, never raises per_qvalid.
        per_req = 1; per_wren = 1; per_addr = 12'h030; per_data = 32'hCAFEF00D;
        #1;
        checks++; if (per_qvalid !== 1'b0)    begin failures++; $display("FAIL per_qvalid_drop got=%b exp=0", per_qvalid); end
        checks++; if (per_q !== 32'h12345678) begin failures++; $display("FAIL per_q_hold got=%h exp=12345678", per_q); end
        checks++; if (per_ack !== 1'b1 || ram_wen !== 1'b1) begin failures++; $display("FAIL per_write_ack got=%b/%b exp=1/1", per_ack, ram_wen); end
        tick();
        idle_inputs();
        #1;
        checks++; if (per_qvalid !== 1'b0) begin failures++; $display("FAIL per_write_qvalid got=%b exp=0", per_qvalid); end
        checks++; if (mem[12'h030] !== 32'hCAFEF00D) begin failures++; $display("FAIL per_write_mem got=%h exp=cafef00d", mem[12'h030]); end
    endtask

    task automatic test_isolation();
        tick();
        cpu_en = 1; cpu_wren = 1; cpu_addr = 12'h001; cpu_data = 32'hAAAA0000;
        tick();
        cpu_addr = 12'h002; cpu_data = 32'h55550000;
        tick();
        cpu_wren = 0; cpu_addr = 12'h001; cpu_data = '0;
        per_req = 1; per_addr = 12'h002;
        // Cycles 0..7 denied, cycle 8 forced grant.
        for (int c = 0; c <= 8; c++) begin
            #1;
            checks++; if (per_ack !== (c == 8)) begin failures++; $display("FAIL iso_ack c=%0d got=%b exp=%b", c, per_ack, (c == 8)); end
            tick();
        end
        per_req = 0;
        #1;
        checks++; if (per_q !== 32'h55550000) begin failures++; $display("FAIL iso_per_q got=%h exp=55550000", per_q); end
        checks++; if (per_qvalid !== 1'b1)    begin failures++; $display("FAIL iso_per_qvalid got=%b exp=1", per_qvalid); end
        checks++; if (cpu_q !== 32'hAAAA0000) begin failures++; $display("FAIL iso_cpu_q got=%h exp=aaaa0000", cpu_q); end
        tick();
        idle_inputs();
        #1;
        checks++; if (cpu_q !== 32'hAAAA0000) begin failures++; $display("FAIL iso_cpu_q_after got=%h exp=aaaa0000", cpu_q); end
    endtask

    task automatic test_starvation();
        tick();
        cpu_en = 1; cpu_addr = 12'h001;
        per_req = 1; per_addr = 12'h020;
        for (int c = 0; c <= 10; c++) begin
            #1;
            checks++; if (per_ack !== (c == 8))   begin failures++; $display("FAIL starve_ack c=%0d got=%b exp=%b", c, per_ack, (c == 8)); end
            checks++; if (cpu_stall !== (c == 8)) begin failures++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, cpu_stall, (c == 8)); end
            if (c == 8) begin
                checks++; if (ram_addr !== 12'h020) begin failures++; $display("FAIL starve_addr got=%h exp=020", ram_addr); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        cpu_en = 1; cpu_addr = 12'h001;
        per_req = 1; per_addr = 12'h020;
        for (int c = 0; c < 5; c++) tick();
        reset = 1;
        #1;
        checks++; if (per_ack !== 1'b0 || cpu_stall !== 1'b0 || ram_wen !== 1'b0) begin
            failures++; $display("FAIL rst_mid_comb got=%b%b%b exp=000", per_ack, cpu_stall, ram_wen);
        end
        tick();
        reset = 0;
        #1;
        checks++; if (cpu_q !== 32'h0 || per_q !== 32'h0 || per_qvalid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_regs got=%h/%h/%b exp=0/0/0", cpu_q, per_q, per_qvalid);
        end
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) #1;
            checks++; if (per_ack !== (c == 8)) begin failures++; $display("FAIL rst_mid_ack c=%0d got=%b exp=%b", c, per_ack, (c == 8)); end
            tick();
        end
        idle_inputs();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        reset = 1;
        tick();
        reset = 0;
        cpu_en = 1; cpu_addr = 12'h001;
        per_req = 1; per_addr = 12'h020;
        // Forced grants land in cycles 8, 17 and 26.
        for (int c = 0; c < 27; c++) tick();
        idle_inputs();
        #1;
        checks++; if (stat_per_grants !== 16'd3) begin failures++; $display("FAIL stat_per_grants got=%0d exp=3", stat_per_grants); end
        checks++; if (stat_stalls !== 16'd3)     begin failures++; $display("FAIL stat_stalls got=%0d exp=3", stat_stalls); end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_only();
        test_per_only();
        test_isolation();
        test_starvation();
        test_reset_mid_wait();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
